// File: rtl/idct_2d.sv
// idct_2d: 8x8 2-D inverse DCT, row pass -> ping-pong transpose -> column pass.
// Coefficients arrive row-major; samples leave column-major, 10 cycles after the last input.
module idct_2d #(
  parameter int BITS = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] in,
  output logic            out_valid,
  output logic [BITS-1:0] O,
  output logic            out_last
);

  localparam int YW  = BITS + 3;
  localparam int AW1 = BITS + 17;
  localparam int AW2 = BITS + 20;

  localparam logic signed [AW1-1:0] Y_HI = AW1'((2**(YW-1)) - 1);
  localparam logic signed [AW1-1:0] Y_LO = AW1'(-(2**(YW-1)));
  localparam logic signed [AW2-1:0] X_HI = AW2'((2**(BITS-1)) - 1);
  localparam logic signed [AW2-1:0] X_LO = AW2'(-(2**(BITS-1)));

  // Q1.12 cosine table folded onto one quarter wave
  function automatic logic signed [13:0] cos_c(
    input logic [2:0] k,
    input logic [2:0] n
  );
    logic [4:0]  m;
    logic [4:0]  idx;
    logic        neg;
    logic [12:0] mag;
    m = {1'b0, n, 1'b1} * {2'b00, k};
    if (m <= 5'd8) begin
      idx = m;
      neg = 1'b0;
    end else if (m <= 5'd16) begin
      idx = 5'd16 - m;
      neg = 1'b1;
    end else if (m <= 5'd24) begin
      idx = m - 5'd16;
      neg = 1'b1;
    end else begin
      idx = 5'd0 - m;
      neg = 1'b0;
    end
    case (idx)
      5'd0:    mag = 13'd2048;
      5'd1:    mag = 13'd2009;
      5'd2:    mag = 13'd1892;
      5'd3:    mag = 13'd1703;
      5'd4:    mag = 13'd1448;
      5'd5:    mag = 13'd1138;
      5'd6:    mag = 13'd784;
      5'd7:    mag = 13'd400;
      default: mag = 13'd0;
    endcase
    if (k == 3'd0) return 14'sd1448;
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic signed [YW-1:0] fin1(
    input logic signed [AW1-1:0] a
  );
    logic signed [AW1-1:0] r;
    r = (a + AW1'(2048)) >>> 12;
    if (r > Y_HI) r = Y_HI;
    if (r < Y_LO) r = Y_LO;
    return r[YW-1:0];
  endfunction

  function automatic logic signed [BITS-1:0] fin2(
    input logic signed [AW2-1:0] a
  );
    logic signed [AW2-1:0] r;
    r = (a + AW2'(2048)) >>> 12;
    if (r > X_HI) r = X_HI;
    if (r < X_LO) r = X_LO;
    return r[BITS-1:0];
  endfunction

  logic [2:0]            col_in_q, col_in_d, row_in_q, row_in_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic signed [AW1-1:0] acc1_q [8];
  logic signed [AW1-1:0] acc1_d [8];
  logic signed [YW-1:0]  tp_q [2][8][8];
  logic signed [YW-1:0]  tp_d [2][8][8];
  logic                  s2_act_q, s2_act_d;
  logic [5:0]            s2_cnt_q, s2_cnt_d;
  logic signed [AW2-1:0] acc2_q [8];
  logic signed [AW2-1:0] acc2_d [8];
  logic                  done_q, done_d, done_last_q, done_last_d;
  logic signed [BITS-1:0] sr_q [8];
  logic signed [BITS-1:0] sr_d [8];
  logic [3:0]            sr_cnt_q, sr_cnt_d;
  logic                  sr_last_q, sr_last_d;
  logic signed [BITS-1:0] o_q, o_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;

  logic                  blk_done, s2_last, pop;
  logic [2:0]            k2;
  logic signed [YW-1:0]  y_rd;
  logic signed [AW1-1:0] base1, sum1;
  logic signed [AW2-1:0] base2;

  assign k2   = s2_cnt_q[2:0];
  assign y_rd = tp_q[rd_bank_q][k2][s2_cnt_q[5:3]];

  always_comb begin
    col_in_d  = col_in_q;
    row_in_d  = row_in_q;
    wr_bank_d = wr_bank_q;
    acc1_d    = acc1_q;
    tp_d      = tp_q;
    blk_done  = 1'b0;
    base1     = '0;
    sum1      = '0;
    if (in_valid) begin
      col_in_d = col_in_q + 3'd1;
      for (int n = 0; n < 8; n++) begin
        base1 = acc1_q[n];
        if (col_in_q == 3'd0) base1 = '0;
        sum1 = base1 + AW1'(cos_c(col_in_q, 3'(n))) * AW1'($signed(in));
        acc1_d[n] = sum1;
        if (col_in_q == 3'd7) tp_d[wr_bank_q][row_in_q][n] = fin1(sum1);
      end
      if (col_in_q == 3'd7) begin
        row_in_d = row_in_q + 3'd1;
        if (row_in_q == 3'd7) begin
          wr_bank_d = ~wr_bank_q;
          blk_done  = 1'b1;
        end
      end
    end
  end

  // A completing block restarts stage 2 even on its final read cycle
  always_comb begin
    s2_act_d  = s2_act_q;
    s2_cnt_d  = s2_cnt_q;
    rd_bank_d = rd_bank_q;
    acc2_d    = acc2_q;
    base2     = '0;
    s2_last   = s2_act_q && (s2_cnt_q == 6'd63);
    if (s2_act_q) begin
      for (int n = 0; n < 8; n++) begin
        base2 = acc2_q[n];
        if (k2 == 3'd0) base2 = '0;
        acc2_d[n] = base2 + AW2'(cos_c(k2, 3'(n))) * AW2'(y_rd);
      end
      s2_cnt_d = s2_cnt_q + 6'd1;
      if (s2_last) s2_act_d = 1'b0;
    end
    if (blk_done) begin
      s2_act_d  = 1'b1;
      s2_cnt_d  = '0;
      rd_bank_d = wr_bank_q;
    end
    done_d      = s2_act_q && (k2 == 3'd7);
    done_last_d = s2_last;
  end

  always_comb begin
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    sr_last_d   = sr_last_q;
    o_d         = o_q;
    pop         = (sr_cnt_q != 4'd0);
    out_valid_d = pop;
    out_last_d  = pop && (sr_cnt_q == 4'd1) && sr_last_q;
    if (pop) begin
      o_d = sr_q[0];
      for (int i = 0; i < 7; i++) sr_d[i] = sr_q[i+1];
      sr_cnt_d = sr_cnt_q - 4'd1;
    end
    if (done_q) begin
      for (int n = 0; n < 8; n++) sr_d[n] = fin2(acc2_q[n]);
      sr_cnt_d  = 4'd8;
      sr_last_d = done_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_in_q    <= '0;
      row_in_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      acc1_q      <= '{default: '0};
      tp_q        <= '{default: '0};
      s2_act_q    <= 1'b0;
      s2_cnt_q    <= '0;
      acc2_q      <= '{default: '0};
      done_q      <= 1'b0;
      done_last_q <= 1'b0;
      sr_q        <= '{default: '0};
      sr_cnt_q    <= '0;
      sr_last_q   <= 1'b0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_in_q    <= col_in_d;
      row_in_q    <= row_in_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      acc1_q      <= acc1_d;
      tp_q        <= tp_d;
      s2_act_q    <= s2_act_d;
      s2_cnt_q    <= s2_cnt_d;
      acc2_q      <= acc2_d;
      done_q      <= done_d;
      done_last_q <= done_last_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      sr_last_q   <= sr_last_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign O         = o_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
